// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream blocks.
// Holds the realigner control bundle and the sink realign FSM states.
package hwpe_stream_package;

    typedef struct packed {
        logic enable;
        logic realign;
        logic first;
        logic last;
        logic last_packet;
    } ctrl_realign_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        MIDDLE = 2'd2,
        LAST   = 2'd3
    } sink_realign_ctrl_state_t;

endpackage

// File: rtl/hwpe_stream_sink_realign_ctrl_if.sv
// Request handshake bundle for the sink realign controller.
// The master issues a transfer; the slave accepts it with ready.
interface hwpe_stream_sink_realign_ctrl_if #(
    parameter int unsigned LEN_WIDTH = 16
);
    logic                 valid;
    logic                 ready;
    logic [31:0]          addr;
    logic [LEN_WIDTH-1:0] len;
    logic                 last_packet;

    modport master (
        output valid, addr, len, last_packet,
        input  ready
    );

    modport slave (
        input  valid, addr, len, last_packet,
        output ready
    );
endinterface

// File: rtl/hwpe_stream_sink_realign_ctrl.sv
// Beat sequencer for the sink realigner: tracks first/middle/last
// beats of a misaligned transfer and produces the byte strobes.
module hwpe_stream_sink_realign_ctrl
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [31:0]             req_addr_i,
    input  logic [LEN_WIDTH-1:0]    req_len_i,
    input  logic                    req_last_packet_i,
    input  logic                    beat_i,
    output ctrl_realign_t           ctrl_o,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned RW = $clog2(SW);
    localparam logic [LEN_WIDTH:0] TOT1 = 1;
    localparam logic [LEN_WIDTH:0] TOT2 = 2;

    sink_realign_ctrl_state_t state_q;

    logic [LEN_WIDTH:0] cnt_q;
    logic [LEN_WIDTH:0] cnt_inc;
    logic [LEN_WIDTH:0] total_q;
    logic [LEN_WIDTH:0] total_d;
    logic [LEN_WIDTH:0] total_m1;
    logic [RW-1:0]      rot_q;
    logic [RW-1:0]      rot_d;
    logic               lp_q;
    logic               done_q;
    logic [SW-1:0]      head;
    logic               unused_addr;

    assign rot_d    = req_addr_i[RW-1:0];
    assign total_d  = {1'b0, req_len_i}
                    + {{LEN_WIDTH{1'b0}}, rot_d != '0};
    assign cnt_inc  = cnt_q + 1'b1;
    assign total_m1 = total_q - 1'b1;
    assign head     = {SW{1'b1}} << rot_q;

    assign unused_addr = ^req_addr_i[31:RW];

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            total_q <= '0;
            rot_q   <= '0;
            lp_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        rot_q   <= rot_d;
                        total_q <= total_d;
                        lp_q    <= req_last_packet_i;
                        cnt_q   <= '0;
                        // zero-length requests complete without any beat
                        if (req_len_i == '0)
                            done_q <= 1'b1;
                        else if (total_d == TOT1)
                            state_q <= LAST;
                        else
                            state_q <= FIRST;
                    end
                end
                FIRST: begin
                    if (beat_i) begin
                        cnt_q   <= cnt_inc;
                        state_q <= (total_q == TOT2) ? LAST : MIDDLE;
                    end
                end
                MIDDLE: begin
                    if (beat_i) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == total_m1)
                            state_q <= LAST;
                    end
                end
                LAST: begin
                    if (beat_i) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_o = '0;
        strb_o = '1;
        if (state_q != IDLE) begin
            ctrl_o.enable  = 1'b1;
            ctrl_o.realign = (rot_q != '0);
        end
        unique case (state_q)
            FIRST: begin
                ctrl_o.first = 1'b1;
                strb_o       = head;
            end
            LAST: begin
                ctrl_o.first       = (total_q == TOT1);
                ctrl_o.last        = 1'b1;
                ctrl_o.last_packet = lp_q;
                if (rot_q != '0 && total_q != TOT1)
                    strb_o = ~head;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hwpe_stream_sink_realign_ctrl.sv
// Directed bench for the sink realign controller with a beat scoreboard.
// Expected beats are queued at request time and popped on each beat.
module tb_hwpe_stream_sink_realign_ctrl;
    import hwpe_stream_package::*;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int SW = DW / 8;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic clear_i = 1'b0;
    logic beat_i  = 1'b0;

    ctrl_realign_t   ctrl_o;
    logic [SW-1:0]   strb_o;
    logic            busy_o;
    logic            done_o;

    hwpe_stream_sink_realign_ctrl_if #(.LEN_WIDTH(LW)) req_if ();

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    always #5 clk_i = ~clk_i;

    hwpe_stream_sink_realign_ctrl #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .req_valid_i      (req_if.valid),
        .req_ready_o      (req_if.ready),
        .req_addr_i       (req_if.addr),
        .req_len_i        (req_if.len),
        .req_last_packet_i(req_if.last_packet),
        .beat_i           (beat_i),
        .ctrl_o           (ctrl_o),
        .strb_o           (strb_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic push_exp(input logic [31:0] addr, input int len,
                            input bit lp);
        int rot;
        int total;
        ctrl_realign_t c;
        logic [3:0] s;
        rot   = int'(addr[1:0]);
        total = len + ((rot != 0) ? 1 : 0);
        for (int i = 0; i < total; i++) begin
            c.enable      = 1'b1;
            c.realign     = (rot != 0);
            c.first       = (i == 0);
            c.last        = (i == total - 1);
            c.last_packet = lp && c.last;
            if (i == 0)
                s = 4'hF << rot;
            else if (c.last && rot != 0)
                s = ~(4'hF << rot);
            else
                s = 4'hF;
            sb.push_back({c, s});
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input int len,
                          input bit lp);
        req_if.valid       = 1'b1;
        req_if.addr        = addr;
        req_if.len         = LW'(len);
        req_if.last_packet = lp;
        chk("req_ready", 32'(req_if.ready), 1);
        cyc();
        req_if.valid = 1'b0;
    endtask

    task automatic run_beats(input bit stall, output int nonlast,
                             output int lastcnt);
        logic [8:0] cur;
        logic [8:0] exp;
        int n;
        nonlast = 0;
        lastcnt = 0;
        n       = 0;
        while (sb.size() != 0 && n < 2000) begin
            cur = {ctrl_o, strb_o};
            chk("busy_in_xfer", 32'(busy_o), 1);
            chk("no_done_in_xfer", 32'(done_o), 0);
            if (stall && $urandom_range(0, 4) == 0) begin
                beat_i = 1'b0;
                chk("stall_hold", 32'(cur), 32'(sb[0]));
            end else begin
                beat_i = 1'b1;
                exp = sb.pop_front();
                chk("beat", 32'(cur), 32'(exp));
                if (ctrl_o.last) lastcnt++;
                else nonlast++;
            end
            cyc();
            n++;
        end
        beat_i = 1'b0;
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    task automatic chk_done();
        chk("done_pulse", 32'(done_o), 1);
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_ctrl", 32'(ctrl_o), 0);
        chk("idle_strb", 32'(strb_o), 32'hF);
        cyc();
        chk("done_clear", 32'(done_o), 0);
    endtask

    initial begin
        int nl;
        int lc;
        logic [8:0] exp;
        req_if.valid       = 1'b0;
        req_if.addr        = '0;
        req_if.len         = '0;
        req_if.last_packet = 1'b0;

        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_ctrl", 32'(ctrl_o), 0);
        chk("rst_strb", 32'(strb_o), 32'hF);
        chk("rst_ready", 32'(req_if.ready), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        rst_ni = 1'b1;
        cyc();

        push_exp(32'h100, 4, 1'b0);
        do_req(32'h100, 4, 1'b0);
        run_beats(1'b0, nl, lc);
        chk("aligned_nonlast", 32'(nl), 3);
        chk("aligned_last", 32'(lc), 1);
        chk_done();

        push_exp(32'h101, 4, 1'b1);
        do_req(32'h101, 4, 1'b1);
        run_beats(1'b0, nl, lc);
        chk("rot1_nonlast", 32'(nl), 4);
        chk("rot1_last", 32'(lc), 1);
        chk_done();

        push_exp(32'h103, 1, 1'b0);
        do_req(32'h103, 1, 1'b0);
        run_beats(1'b0, nl, lc);
        chk("rot3_nonlast", 32'(nl), 1);
        chk("rot3_last", 32'(lc), 1);
        chk_done();

        push_exp(32'h100, 1, 1'b1);
        do_req(32'h100, 1, 1'b1);
        run_beats(1'b0, nl, lc);
        chk("single_nonlast", 32'(nl), 0);
        chk("single_last", 32'(lc), 1);
        chk_done();

        do_req(32'h100, 0, 1'b0);
        chk("zero_len_done", 32'(done_o), 1);
        chk("zero_len_ctrl", 32'(ctrl_o), 0);
        chk("zero_len_busy", 32'(busy_o), 0);
        cyc();
        chk("zero_len_done_clr", 32'(done_o), 0);

        push_exp(32'h102, 16, 1'b0);
        do_req(32'h102, 16, 1'b0);
        run_beats(1'b1, nl, lc);
        chk("stall_nonlast", 32'(nl), 16);
        chk("stall_last", 32'(lc), 1);
        chk_done();

        push_exp(32'h100, 8, 1'b0);
        do_req(32'h100, 8, 1'b0);
        for (int i = 0; i < 2; i++) begin
            beat_i = 1'b1;
            exp = sb.pop_front();
            chk("pre_clear_beat", 32'({ctrl_o, strb_o}), 32'(exp));
            cyc();
        end
        beat_i = 1'b0;
        chk("middle_ctrl", 32'({ctrl_o, strb_o}), 32'(sb[0]));
        clear_i = 1'b1;
        beat_i  = 1'b1;
        cyc();
        clear_i = 1'b0;
        beat_i  = 1'b0;
        sb.delete();
        chk("clr_busy", 32'(busy_o), 0);
        chk("clr_ctrl", 32'(ctrl_o), 0);
        chk("clr_strb", 32'(strb_o), 32'hF);
        chk("clr_no_done", 32'(done_o), 0);
        push_exp(32'h101, 1, 1'b0);
        do_req(32'h101, 1, 1'b0);
        chk("post_clr_no_done", 32'(done_o), 0);
        run_beats(1'b0, nl, lc);
        chk("post_clr_nonlast", 32'(nl), 1);
        chk("post_clr_last", 32'(lc), 1);
        chk_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
